// File: rtl/lfsr_engine.sv
// lfsr_engine: run-time programmable LFSR (Fibonacci or Galois structure).
//
// A load strobe captures seed, tap mask and structure and starts a run.
// Each enabled cycle in RUN advances the register one step. When the
// register returns to the captured seed the engine enters DONE and
// period_count holds the measured sequence period.
//
// Build option:
//   LFSR_LOCKUP_DETECT_EN - when defined, loading an all-zero seed traps in
//                           ERR with lfsr_error=1. When undefined, a zero
//                           seed loads normally and lfsr_error is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   load_seed    in   capture seed_data/tap_mask/galois_mode, start a run
//   seed_data    in   N-bit initial register value
//   tap_mask     in   N-bit tap mask, bit i = exponent i+1 (MSB forced to 1)
//   galois_mode  in   0 = Fibonacci, 1 = Galois (captured on load)
//   step_en      in   advance one step this cycle (RUN only)
//   lfsr_data    out  current register state
//   lfsr_done    out  high while in DONE
//   period_count out  steps taken since the last load
//   lfsr_error   out  lock-up flag (only ever set with LFSR_LOCKUP_DETECT_EN)
//   dbg_state_o  out  FSM state for observation (0 IDLE,1 RUN,2 DONE,3 ERR)
//
// Handshake: inputs are sampled on the rising clock edge; there is no
// valid/ready pairing. Priority is reset > load_seed > step_en, and a load
// with step_en in the same cycle loads without stepping.

module lfsr_engine #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_seed,
    input  logic [N-1:0] seed_data,
    input  logic [N-1:0] tap_mask,
    input  logic         galois_mode,
    input  logic         step_en,
    output logic [N-1:0] lfsr_data,
    output logic         lfsr_done,
    output logic [N-1:0] period_count,
    output logic         lfsr_error,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    localparam logic [N-1:0] MSB_ONE = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] data_q,  data_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] seed_q,  seed_d;
    logic [N-1:0] tap_q,   tap_d;
    logic         mode_q,  mode_d;
    logic         done_q,  done_d;
`ifdef LFSR_LOCKUP_DETECT_EN
    logic         err_q,   err_d;
`endif

    logic [N-1:0] fib_next;
    logic [N-1:0] gal_next;
    logic [N-1:0] step_next;
    logic         fib_fb;
    logic         gal_msb;

    // Next-state functions of the current register value. tap_q[N-1] is
    // always set, which keeps both structures invertible.
    always_comb begin
        fib_fb   = ^(data_q & tap_q);
        fib_next = {data_q[N-2:0], fib_fb};

        gal_msb     = data_q[N-1];
        gal_next    = '0;
        gal_next[0] = gal_msb;
        for (int i = 1; i < N; i++) begin
            gal_next[i] = data_q[i-1] ^ (gal_msb & tap_q[i-1]);
        end

        step_next = mode_q ? gal_next : fib_next;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        seed_d  = seed_q;
        tap_d   = tap_q;
        mode_d  = mode_q;
        done_d  = done_q;
`ifdef LFSR_LOCKUP_DETECT_EN
        err_d   = err_q;
`endif

        if (load_seed) begin
            // A load restarts from any state and suppresses a same-cycle step.
            seed_d  = seed_data;
            tap_d   = tap_mask | MSB_ONE;
            mode_d  = galois_mode;
            data_d  = seed_data;
            count_d = '0;
            done_d  = 1'b0;
            state_d = S_RUN;
`ifdef LFSR_LOCKUP_DETECT_EN
            err_d   = 1'b0;
            if (seed_data == '0) begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    if (step_en) begin
                        data_d  = step_next;
                        count_d = count_q + ONE;
                        if (step_next == seed_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                // IDLE, DONE and ERR hold until a load or reset.
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            count_q <= '0;
            seed_q  <= '0;
            tap_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LFSR_LOCKUP_DETECT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            seed_q  <= seed_d;
            tap_q   <= tap_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
`ifdef LFSR_LOCKUP_DETECT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign lfsr_data    = data_q;
    assign lfsr_done    = done_q;
    assign period_count = count_q;
    assign dbg_state_o  = state_q;
`ifdef LFSR_LOCKUP_DETECT_EN
    assign lfsr_error   = err_q;
`else
    assign lfsr_error   = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_engine.sv
// Testbench for lfsr_engine (N=4). Expected results are packed as
// {state, error, done, count, data} and pushed to a queue when the stimulus
// for a cycle is driven; they are popped and compared #1 after the edge.

module tb_lfsr_engine;

    localparam int N = 4;
    localparam int W = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic         clk;
    logic         reset;
    logic         load_seed;
    logic [N-1:0] seed_data;
    logic [N-1:0] tap_mask;
    logic         galois_mode;
    logic         step_en;
    logic [N-1:0] lfsr_data;
    logic         lfsr_done;
    logic [N-1:0] period_count;
    logic         lfsr_error;
    logic [1:0]   dbg_state;

    lfsr_engine #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_seed    (load_seed),
        .seed_data    (seed_data),
        .tap_mask     (tap_mask),
        .galois_mode  (galois_mode),
        .step_en      (step_en),
        .lfsr_data    (lfsr_data),
        .lfsr_done    (lfsr_done),
        .period_count (period_count),
        .lfsr_error   (lfsr_error),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // ---------------- reference model state ----------------
    logic [1:0]   m_state;
    logic [N-1:0] m_data, m_count, m_seed, m_tap;
    logic         m_mode, m_done, m_err;

    function automatic logic [N-1:0] ref_fib(input logic [N-1:0] s, input logic [N-1:0] t);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < N; i++) fb = fb ^ (s[i] & t[i]);
        return {s[N-2:0], fb};
    endfunction

    function automatic logic [N-1:0] ref_gal(input logic [N-1:0] s, input logic [N-1:0] t);
        logic [N-1:0] r;
        r = {s[N-2:0], s[N-1]};
        if (s[N-1]) r = r ^ {t[N-2:0], 1'b0};
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input string name, input logic rst, input logic ld,
                         input logic [N-1:0] sd, input logic [N-1:0] mk,
                         input logic md, input logic st, input logic [W-1:0] exp);
        logic [W-1:0] got, e;
        @(negedge clk);
        reset       = rst;
        load_seed   = ld;
        seed_data   = sd;
        tap_mask    = mk;
        galois_mode = md;
        step_en     = st;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got = {dbg_state, lfsr_error, lfsr_done, period_count, lfsr_data};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got state=%0d err=%b done=%b count=%0d data=%b, exp state=%0d err=%b done=%b count=%0d data=%b",
                     name, got[11:10], got[9], got[8], got[7:4], got[3:0],
                     e[11:10], e[9], e[8], e[7:4], e[3:0]);
        end
    endtask

    // Drive one cycle, advancing the reference model to build the expectation.
    task automatic mcyc(input string name, input logic rst, input logic ld,
                        input logic [N-1:0] sd, input logic [N-1:0] mk,
                        input logic md, input logic st);
        logic [N-1:0] nx;
        if (rst) begin
            m_state = ST_IDLE; m_data = '0; m_count = '0; m_seed = '0;
            m_tap = '0; m_mode = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end else if (ld) begin
            m_seed = sd; m_tap = mk | 4'b1000; m_mode = md;
            m_data = sd; m_count = '0; m_done = 1'b0; m_err = 1'b0;
            m_state = ST_RUN;
`ifdef LFSR_LOCKUP_DETECT_EN
            if (sd == '0) begin
                m_state = ST_ERR;
                m_err   = 1'b1;
            end
`endif
        end else if (m_state == ST_RUN && st) begin
            nx = m_mode ? ref_gal(m_data, m_tap) : ref_fib(m_data, m_tap);
            m_data  = nx;
            m_count = m_count + 4'd1;
            if (nx == m_seed) begin
                m_state = ST_DONE;
                m_done  = 1'b1;
            end
        end
        apply(name, rst, ld, sd, mk, md, st, {m_state, m_err, m_done, m_count, m_data});
    endtask

    task automatic check_val(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // ---------------- Fibonacci vector table ----------------
    typedef struct {
        logic         step;
        logic [N-1:0] exp_data;
        logic [N-1:0] exp_count;
        logic         exp_done;
        logic [1:0]   exp_state;
    } vec_t;

    vec_t fib_tab[17];

    initial begin
        logic [N-1:0] seq[15];
        seq = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000,
                4'b0001};
        for (int i = 0; i < 15; i++) begin
            fib_tab[i] = '{1'b1, seq[i], 4'(i + 1), (i == 14),
                           (i == 14) ? ST_DONE : ST_RUN};
        end
        // Steps in DONE are ignored: seed and period are held.
        fib_tab[15] = '{1'b1, 4'b0001, 4'd15, 1'b1, ST_DONE};
        fib_tab[16] = '{1'b0, 4'b0001, 4'd15, 1'b1, ST_DONE};

        reset = 1'b1; load_seed = 1'b0; seed_data = '0; tap_mask = '0;
        galois_mode = 1'b0; step_en = 1'b0;

        // Reset and idle.
        mcyc("reset0", 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        mcyc("reset1", 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) mcyc("idle_step", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

        // Fibonacci maximal length, table driven.
        mcyc("fib_load", 1'b0, 1'b1, 4'b0001, 4'b1100, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            apply("fib_vec", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, fib_tab[i].step,
                  {fib_tab[i].exp_state, 1'b0, fib_tab[i].exp_done,
                   fib_tab[i].exp_count, fib_tab[i].exp_data});
        end

        // Galois run; load and same-cycle step only loads.
        mcyc("gal_load", 1'b0, 1'b1, 4'b0001, 4'b1001, 1'b1, 1'b1);
        for (int i = 0; i < 20 && m_state == ST_RUN; i++)
            mcyc("gal_step", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        check_val("gal_period", period_count, 4'd15);
        check_val("gal_done", {3'b0, lfsr_done}, 4'd1);

        // Gated stepping: 15 enabled cycles spread over 30.
        mcyc("gate_load", 1'b0, 1'b1, 4'b0001, 4'b1100, 1'b0, 1'b0);
        for (int i = 0; i < 29; i++)
            mcyc("gate_step", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, (i % 2) == 0);
        check_val("gate_period", period_count, 4'd15);

        // Restart at count 7 with step_en high in the same cycle.
        mcyc("rst7_load", 1'b0, 1'b1, 4'b0001, 4'b1100, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) mcyc("rst7_step", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        apply("reload", 1'b0, 1'b1, 4'b1010, 4'b1100, 1'b0, 1'b1, {ST_RUN, 1'b0, 1'b0, 4'd0, 4'b1010});
        mcyc("reload_sync", 1'b0, 1'b1, 4'b1010, 4'b1100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) mcyc("reload_step", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

        // Lock-up.
`ifdef LFSR_LOCKUP_DETECT_EN
        apply("lock_load", 1'b0, 1'b1, 4'b0000, 4'b1100, 1'b0, 1'b0, {ST_ERR, 1'b1, 1'b0, 4'd0, 4'd0});
        mcyc("lock_sync", 1'b0, 1'b1, 4'b0000, 4'b1100, 1'b0, 1'b0);
        mcyc("lock_hold", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        mcyc("lock_hold", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        apply("lock_clear", 1'b0, 1'b1, 4'b0001, 4'b1100, 1'b0, 1'b0, {ST_RUN, 1'b0, 1'b0, 4'd0, 4'b0001});
`else
        mcyc("zero_load", 1'b0, 1'b1, 4'b0000, 4'b1100, 1'b0, 1'b0);
        apply("zero_step", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, {ST_DONE, 1'b0, 1'b1, 4'd1, 4'd0});
`endif

        // Reset mid-run at step 9, then steps have no effect.
        mcyc("mid_load", 1'b0, 1'b1, 4'b0001, 4'b1001, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) mcyc("mid_step", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        mcyc("mid_reset", 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) mcyc("post_reset", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_engine.md
# lfsr_engine

Parametrised, run-time-programmable linear feedback shift register for the course datapath library, generalising the fixed-polynomial N-bit LFSR. It takes seed, tap mask and structure (Fibonacci or Galois) on a load strobe, then steps under an enable. It detects return to the seed, reports the measured sequence period, and optionally traps the all-zero lock-up state. Pattern-generator and scrambler test benches use it wherever a fixed polynomial is too rigid.

## Interface
- N, 4, register width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load_seed  input  1  captures seed_data, tap_mask and galois_mode, then starts a run.
- seed_data  input  N  initial register value.
- tap_mask  input  N  bit i set means stage i is tapped (exponent i+1); bit N-1 is forced to 1 internally.
- galois_mode  input  1  0 selects Fibonacci, 1 selects Galois; captured on load.
- step_en  input  1  advance one step in this cycle (RUN state only).
- lfsr_data  output  N  current register state.
- lfsr_done  output  1  high while in DONE.
- period_count  output  N  steps taken since the last load.
- lfsr_error  output  1  lock-up flag; see Configuration.

## Operation
- FSM states: IDLE, RUN, DONE, ERR.
- Taps: seed_reg, tap_reg and mode_reg are loaded only on load_seed; tap_reg[N-1] is always 1.
- Fibonacci step:
  - fb = XOR over all i of (s[i] & tap_reg[i]).
  - next = {s[N-2:0], fb}.
  - Example: N=4, mask 1100 gives xor = s[3]^s[2], i.e. x^4+x^3+1.
- Galois step:
  - m = s[N-1].
  - next[0] = m.
  - next[i] = s[i-1] ^ (m & tap_reg[i-1]) for i = 1..N-1.
- IDLE: outputs hold; step_en ignored; load_seed goes to RUN.
- RUN, step_en=1:
  - lfsr_data <= next; period_count <= period_count+1.
  - If next == seed_reg, go to DONE on the same edge.
- RUN, step_en=0: everything holds.
- DONE:
  - lfsr_data equals seed_reg, period_count holds the period, lfsr_done=1.
  - step_en ignored; load_seed restarts the run.
- Priority (highest first): reset, then load_seed, then step_en.
  - load_seed in any state restarts: lfsr_data <= seed_data, period_count <= 0, lfsr_done <= 0, lfsr_error <= 0, state RUN.
  - load_seed and step_en in the same cycle: load only, no step.
- With bit N-1 tapped, both structures are invertible, so any nonzero seed returns within 2^N-1 steps. period_count therefore never overflows N bits.

## Timing
- Reset values: lfsr_data=0, lfsr_done=0, period_count=0, lfsr_error=0, state IDLE.
- Load: one cycle of latency; the seed appears on lfsr_data at the edge that samples load_seed.
- Step: one step per enabled cycle, visible after that edge; no combinational path from inputs to outputs.
- lfsr_done rises on the same edge that restores the seed. It stays high until the next load or reset.
- Reset mid-run: the run is abandoned, all outputs return to reset values, and seed, tap and mode registers clear to 0.

## Configuration
- Macro LFSR_LOCKUP_DETECT_EN.
- Defined:
  - A load with seed_data == 0 enters ERR: lfsr_error=1, lfsr_data=0, period_count=0, lfsr_done=0.
  - ERR ignores step_en and is left only by reset or a load with a nonzero seed.
- Undefined:
  - A zero seed loads normally. The first enabled step produces 0 == seed_reg, giving DONE with period_count=1.
  - lfsr_error is tied to 0.
- The port list is identical in both builds.

## Test plan
- Reset and idle: hold reset 2 cycles, release, then pulse step_en 5 cycles. Required: all outputs stay 0 and state stays IDLE.
- Fibonacci maximal length: N=4, seed 0001, mask 1100, mode 0, step_en held high.
  - lfsr_data runs 0010, 0100, 1001, 0011, 0110, 1101, …, 1000, 0001.
  - lfsr_done rises with 0001 after 15 steps; period_count=15.
- Galois run: N=4, seed 0001, mask 1001, mode 1. Required: done with period_count=15, and every intermediate state matches the reference-model step function.
- Gated stepping and restart:
  - Same setup as the Fibonacci test with step_en toggling 1/0. Required: period_count=15 only after 15 enabled cycles.
  - Reload at count 7 with seed 1010 and step_en=1 in the same cycle. Required: lfsr_data=1010, period_count=0, no step taken.
- Lock-up: load seed 0000.
  - Macro defined: lfsr_error=1; a later load of 0001 clears the error and enters RUN.
  - Macro undefined: done after 1 step with period_count=1.
- Reset mid-run: assert reset at step 9. Required: next cycle has lfsr_data=0, period_count=0 and state IDLE; step_en then has no effect.
